// File: rtl/vpll_pkg.sv
// Shared state encoding and reconfig-controller register map for the video PLL sequencer.
package vpll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_MIF,
    GAP,
    WR_START,
    WAIT_LOCK,
    DONE
  } state_t;

  localparam logic [5:0] REG_MIF_BASE = 6'd31;
  localparam logic [5:0] REG_START    = 6'd2;

  // MIF base offset for a select code, truncated to the 32-bit mgmt data bus.
  function automatic logic [31:0] mif_word(input logic [31:0] sel, input int shift);
    return sel << shift;
  endfunction

endpackage

// File: rtl/vpll_reconfig_seq_sync_filter.sv
// 2-flop synchroniser plus stability counter: stable rises once cand has been seen
// unchanged for SETTLE_CYCLES consecutive synced cycles.
module sync_filter #(
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic             CLK_50M,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] cand,
  output logic             stable
);

  localparam int               CNT_W   = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  logic [SEL_W-1:0] sel_m;
  logic [SEL_W-1:0] sel_s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      sel_m <= '0;
      sel_s <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sel_m <= sel_in;
      sel_s <= sel_m;
      if (sel_s != cand) begin
        cand <= sel_s;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/vpll_reconfig_seq.sv
// Turns a debounced video clock select into MIF-base + START writes on the PLL reconfig
// mgmt port; writes hold while waitrequest is high, then waits for lock or timeout.
module vpll_reconfig_seq #(
  parameter int SEL_W         = 2,
  parameter int MIF_SHIFT     = 6,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MIN_WAIT      = 16,
  parameter int LOCK_TIMEOUT  = 65535
) (
  input  logic             CLK_50M,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel_in,
  output logic [5:0]       mgmt_address,
  output logic [31:0]      mgmt_writedata,
  output logic             mgmt_write,
  input  logic             mgmt_waitrequest,
  input  logic             pll_locked,
  output logic             busy,
  output logic [SEL_W-1:0] cur_sel,
  output logic             err,
  output logic             done
);

  import vpll_pkg::*;

  localparam int                WAIT_W    = $clog2(LOCK_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MIN  = WAIT_W'(MIN_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);

  state_t            state;
  logic [SEL_W-1:0]  cand;
  logic              stable;
  logic [SEL_W-1:0]  tgt;
  logic              init_pending;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lock_m;
  logic              lock_s;

  sync_filter #(
    .SEL_W        (SEL_W),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_sync_filter (
    .CLK_50M(CLK_50M),
    .reset  (reset),
    .sel_in (sel_in),
    .cand   (cand),
    .stable (stable)
  );

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state          <= IDLE;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      cur_sel        <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
      tgt            <= '0;
      init_pending   <= 1'b1;
      wait_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // init_pending forces one sequence after reset even if the select equals cur_sel.
          if (stable && (cand != cur_sel || init_pending)) begin
            tgt            <= cand;
            init_pending   <= 1'b0;
            busy           <= 1'b1;
            mgmt_write     <= 1'b1;
            mgmt_address   <= REG_MIF_BASE;
            mgmt_writedata <= mif_word(32'(cand), MIF_SHIFT);
            state          <= WR_MIF;
          end
        end
        WR_MIF: begin
          if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            state      <= GAP;
          end
        end
        GAP: begin
          mgmt_write     <= 1'b1;
          mgmt_address   <= REG_START;
          mgmt_writedata <= '0;
          state          <= WR_START;
        end
        WR_START: begin
          if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            wait_cnt   <= '0;
            state      <= WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          // Lock wins over timeout when both land on the same cycle.
          if (wait_cnt >= WAIT_MIN && lock_s && !mgmt_waitrequest) begin
            err     <= 1'b0;
            cur_sel <= tgt;
            done    <= 1'b1;
            state   <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            err     <= 1'b1;
            cur_sel <= tgt;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mgmt_write <= 1'b0;
          done       <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vpll_reconfig_seq.md
Name: vpll_reconfig_seq

Overview:
- Sequencer on CLK_50M that turns the video base-clock select from the Archimedes core (VIDBASECLK_O, 2 bits, clk_32m domain) into Avalon-MM management writes to the video PLL reconfiguration controller (altera_pll_reconfig_top, MIF mode, WAIT_FOR_LOCK=1).
- Sits directly upstream of that controller's mgmt port and downstream of the core's select output.
- Synchronises and debounces the select, issues the MIF-base and START writes, waits for lock, and reports status.

Parameters:
- SEL_W, 2, width of the clock-select code.
- MIF_SHIFT, 6, MIF base offset = sel << MIF_SHIFT.
- SETTLE_CYCLES, 1024, consecutive stable synced cycles required before a select is applied; minimum 2.
- MIN_WAIT, 16, cycles after START acceptance before pll_locked is sampled.
- LOCK_TIMEOUT, 65535, cycles in WAIT_LOCK before timeout.

Ports:
- CLK_50M  in  1  clock
- reset  in  1  synchronous, active-high
- sel_in  in  SEL_W  asynchronous select from clk_32m domain
- mgmt_address  out  6  reconfig register address
- mgmt_writedata  out  32  reconfig write data
- mgmt_write  out  1  write request
- mgmt_waitrequest  in  1  controller stall
- pll_locked  in  1  video PLL lock, asynchronous
- busy  out  1  sequence in progress
- cur_sel  out  SEL_W  last applied select
- err  out  1  sticky lock-timeout flag
- done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset values: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, cur_sel=0, err=0, done=0, state=IDLE, init_pending=1, stable counter=0.
- Synchronisers:
  - sel_in passes through a 2-flop synchroniser to sel_s.
  - pll_locked passes through a 2-flop synchroniser to lock_s.
- Stability filter:
  - Holds cand and cnt.
  - If sel_s != cand: cand<=sel_s, cnt<=0.
  - Otherwise cnt increments, saturating at SETTLE_CYCLES-1.
  - stable = (cnt == SETTLE_CYCLES-1).
- Start condition, evaluated in IDLE only: stable && (cand != cur_sel || init_pending).
  - On start: latch tgt<=cand, clear init_pending.
- Avalon write rule:
  - mgmt_write, mgmt_address and mgmt_writedata stay stable while mgmt_waitrequest=1.
  - A write is accepted on a cycle with mgmt_write=1 and mgmt_waitrequest=0.
  - mgmt_write deasserts on the following cycle.
- States:
  - IDLE: busy=0. On start condition, go to WR_MIF.
  - WR_MIF: mgmt_write=1, address=31, data = zero-extended tgt << MIF_SHIFT (tgt=2 gives 0x80). On acceptance, go to GAP.
  - GAP: one cycle with mgmt_write=0, then go to WR_START.
  - WR_START: mgmt_write=1, address=2, data=0. On acceptance, clear the wait counter and go to WAIT_LOCK.
  - WAIT_LOCK: wait counter increments every cycle.
    - After MIN_WAIT cycles, if lock_s=1 && mgmt_waitrequest=0: go to DONE.
    - If the counter reaches LOCK_TIMEOUT: err<=1, go to DONE.
  - DONE: cur_sel<=tgt, done=1 for one cycle, err cleared if the lock succeeded, go to IDLE.
- busy=1 in every state except IDLE.
- Latency: the first mgmt_write rises 2 (sync) + SETTLE_CYCLES + 1 cycles after a sel_in change.
- Select change during a sequence:
  - The sequence is not aborted and tgt is unchanged.
  - The filter keeps running; a new sequence starts in IDLE once the new value has been stable and differs from cur_sel.
- A select glitch shorter than SETTLE_CYCLES never starts a sequence.
- Timeout: cur_sel still updates, so the block does not retry the same code forever. err stays set until a later sequence locks.
- After reset, exactly one sequence runs for the stable select, even when it equals 0.
- Reset mid-sequence: all outputs return to reset values on the next edge, mgmt_write drops immediately, and init_pending=1 forces a fresh sequence. The controller shares the same reset.
- Widths: the counters are sized by $clog2 of their parameter. The shift result is truncated to 32 bits.

Decomposition:
- Shared package vpll_pkg holds:
  - state enum (IDLE, WR_MIF, GAP, WR_START, WAIT_LOCK, DONE)
  - localparams REG_MIF_BASE=6'd31, REG_START=6'd2
- One natural sub-module, sync_filter: the 2-flop synchroniser plus stability counter for a SEL_W-bit bus, outputs cand and stable. The FSM stays in vpll_reconfig_seq.

Test Plan:
Bench parameters: SETTLE_CYCLES=16, MIN_WAIT=4, LOCK_TIMEOUT=100.
- Reset release, sel_in=0, waitrequest=0, locked=1 -> write (31, 0x00), then write (2, 0x0), done pulse, cur_sel=0, err=0, exactly 2 writes.
- sel_in 0->2, held -> first mgmt_write 19 cycles after the change, data 0x80 at address 31, then address 2, cur_sel=2.
- sel_in pulses to 3 for 10 cycles, returns to previous value -> no mgmt_write, busy stays 0.
- waitrequest held high 7 cycles during WR_MIF -> mgmt_write/address/data stable for all 8 cycles, single acceptance, no duplicate write.
- locked held low after START -> err=1 after 100 WAIT_LOCK cycles, done pulses, cur_sel updated; next sel change with lock present clears err.
- reset asserted in WAIT_LOCK -> next cycle mgmt_write=0, busy=0, err=0; after release a full sequence reruns for the current sel.
